dn_sink: RTL and testbench
==========================

# dn_sink

Core-side receiver for the boot/download byte stream produced by the top-level loader (dn_go / dn_wr / dn_addr / dn_data, execute_addr / execute_enable). It buffers incoming bytes in a small FIFO and writes them to system RAM through a request/acknowledge port. It holds the CPU in reset while a download or drain is in progress. Once the last byte is committed, it issues a one-cycle execute command carrying the start address.

## Interface
- ADDR_W, 16: width of dn_addr, execute_addr, mem_addr and exec_addr.
- FIFO_DEPTH, 4: buffer entries; power of two, at least 2.

- clk_sys  in  1  system clock; every event is sampled on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dn_go  in  1  download session active (level).
- dn_wr  in  1  one-cycle byte strobe; honoured only while dn_go=1.
- dn_addr  in  ADDR_W  target address of the strobed byte.
- dn_data  in  8  byte value.
- execute_addr  in  ADDR_W  start address, sampled with execute_enable.
- execute_enable  in  1  one-cycle execute request.
- mem_req  out  1  write request; stays high until mem_ack.
- mem_addr  out  ADDR_W  write address; stable while mem_req=1.
- mem_dout  out  8  write data; stable while mem_req=1.
- mem_ack  in  1  one-cycle write completion; ignored when mem_req=0.
- cpu_hold  out  1  keeps the CPU in reset.
- exec_valid  out  1  one-cycle execute command.
- exec_addr  out  ADDR_W  jump address; valid with exec_valid and held until the next exec.
- overflow  out  1  sticky flag: a byte was dropped.
- byte_count  out  ADDR_W+1  number of bytes accepted since the last dn_go rising edge; saturates at all-ones.

## Operation
- Accept: a byte is accepted on a cycle with dn_go=1 and dn_wr=1 when the FIFO is not full, or when a pop occurs in the same cycle. The entry pushed is {dn_addr, dn_data}. byte_count increments by 1.
- Drop: a strobe arriving with the FIFO full and no pop is discarded. overflow is set and byte_count does not increment.
- dn_go rising edge (registered detect): clears overflow and byte_count. It does not flush the FIFO.
- The write FSM has three states: IDLE, WRITE and EXEC.
- IDLE:
  - If the FIFO is non-empty: pop the head into the mem_addr/mem_dout registers, set mem_req=1 and go to WRITE.
  - Otherwise, if exec_pending=1, dn_go=0 and the FIFO is empty: go to EXEC.
- WRITE:
  - On mem_ack with the FIFO non-empty: pop the next entry into the registers the same cycle and keep mem_req=1, so consecutive writes have no bubble.
  - On mem_ack with the FIFO empty: clear mem_req and return to IDLE.
- EXEC:
  - exec_valid=1 for exactly one cycle, with exec_addr = the latched address.
  - Clear exec_pending and return to IDLE.
- execute_enable: sets exec_pending and latches execute_addr, in any state and regardless of dn_go. A second pulse before EXEC overwrites the latched address; only one exec_valid results.
- cpu_hold = dn_go OR fifo non-empty OR mem_req OR exec_pending OR (state==EXEC). It is a registered output.
- dn_go falling with no execute_enable: the FIFO drains normally, then cpu_hold drops and no exec is issued.
- Asynchronous reset mid-operation:
  - The FIFO and all pending requests are discarded.
  - Every output returns to its reset value immediately.
  - A write in flight is abandoned; a late mem_ack after reset is ignored.

## Timing
- Reset values of all outputs are 0: mem_req, mem_addr, mem_dout, exec_valid, exec_addr, overflow and byte_count. cpu_hold is 1 during reset and falls on the first edge after release only if all hold terms are 0.
- Strobe on edge N (FIFO empty, IDLE): the entry is visible at N+1, and mem_req=1 with the byte's address/data from N+2.
- mem_ack at edge M with more data: the new address/data are presented from M+1.
- Final mem_ack at M with exec_pending and dn_go=0: IDLE at M+1, EXEC at M+2, exec_valid high during M+2.
- cpu_hold falls at M+3.
- Throughput: a strobe every 2 cycles with mem_ack latency of 1 never overflows at FIFO_DEPTH=4.
- Simultaneous push and pop with the FIFO full is accepted, and the count is unchanged.

## Test plan
- Stream: dn_go=1; bytes 0xA0..0xA9 to 0x0000..0x0009 every 2 cycles; mem_ack 1 cycle after each req. Required: 10 writes in order with matching address/data, byte_count=10, overflow=0.
- Execute: after the stream, execute_enable with execute_addr=0x0000 in the same cycle dn_go falls. Required: exec_valid once with exec_addr=0x0000, only after the last mem_ack; cpu_hold falls one cycle later.
- Backpressure: withhold mem_ack for 20 cycles while 7 strobes arrive. Required: the first 5 are accepted (1 in the output register plus 4 in the FIFO), overflow=1, byte_count=5, and the remaining writes complete after ack resumes.
- Stability: during a stalled mem_req, toggle dn_data/dn_addr. Required: mem_addr/mem_dout are unchanged until ack.
- No execute: drop dn_go without execute_enable. Required: the FIFO drains, no exec_valid, and cpu_hold falls after the final ack.
- Reset mid-write: assert reset_n=0 with 3 bytes queued and mem_req=1; release, then pulse mem_ack. Required: all outputs 0, no write issued, and overflow/byte_count are 0.

Source files
------------

// File: rtl/dn_sink.sv
// dn_sink - receiver for the boot/download byte stream.
//
// Bytes strobed in while a download session is active are buffered in a
// small FIFO. A three-state write engine (IDLE / WRITE / EXEC) then commits
// them to system RAM through a request/acknowledge port. The CPU is held in
// reset while a session, a drain or an execute is outstanding. Once the
// last byte has been committed, a one-cycle execute command is issued.
//
// Ports:
//   clk_sys        in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   dn_go          in   download session active (level)
//   dn_wr          in   one-cycle byte strobe, honoured only while dn_go=1
//   dn_addr        in   [ADDR_W]   target address of the strobed byte
//   dn_data        in   [8]        byte value
//   execute_addr   in   [ADDR_W]   start address, sampled with execute_enable
//   execute_enable in   one-cycle execute request
//   mem_req        out  write request, held until mem_ack
//   mem_addr       out  [ADDR_W]   write address, stable while mem_req=1
//   mem_dout       out  [8]        write data, stable while mem_req=1
//   mem_ack        in   one-cycle write completion
//   cpu_hold       out  keeps the CPU in reset (registered)
//   exec_valid     out  one-cycle execute command
//   exec_addr      out  [ADDR_W]   jump address, held until the next exec
//   overflow       out  sticky: a byte was dropped this session
//   byte_count     out  [ADDR_W+1] bytes accepted this session, saturating
module dn_sink #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_go,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  input  logic [ADDR_W-1:0] execute_addr,
  input  logic              execute_enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic              cpu_hold,
  output logic              exec_valid,
  output logic [ADDR_W-1:0] exec_addr,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + 8;
  localparam logic [PTR_W:0]  PTR_ONE = 1;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] head;

  logic               push, drop, pop;
  logic               go_rise;
  logic               load_exec;

  logic               dn_go_q;
  logic               exec_pending_q, exec_pending_d;
  logic [ADDR_W-1:0]  exec_latch_q;
  logic [ADDR_W-1:0]  exec_addr_q, exec_addr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_dout_q, mem_dout_d;
  logic               overflow_q, overflow_d;
  logic [ADDR_W:0]    byte_count_q, byte_count_d;
  logic               cpu_hold_q, cpu_hold_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push    = dn_go && dn_wr && (!fifo_full || pop);
  assign drop    = dn_go && dn_wr && !push;
  assign go_rise = dn_go && !dn_go_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_WRITE;
        end else if (exec_pending_q && !dn_go) begin
          state_d = S_EXEC;
        end
      end
      S_WRITE: begin
        if (mem_ack && fifo_empty) begin
          state_d = S_IDLE;
        end
      end
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // mem_req is exactly "in WRITE": entering WRITE always loads a byte and
  // leaving it always follows the final ack.
  always_comb begin
    pop        = 1'b0;
    mem_req    = 1'b0;
    exec_valid = 1'b0;
    load_exec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop       = !fifo_empty;
        load_exec = (state_d == S_EXEC);
      end
      S_WRITE: begin
        mem_req = 1'b1;
        pop     = mem_ack && !fifo_empty;
      end
      S_EXEC: begin
        exec_valid = 1'b1;
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    wr_ptr_d       = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d       = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    mem_addr_d     = mem_addr_q;
    mem_dout_d     = mem_dout_q;
    if (pop) begin
      mem_addr_d = head[ENTRY_W-1:8];
      mem_dout_d = head[7:0];
    end

    // A new request landing in the EXEC cycle must survive the clear.
    exec_pending_d = exec_pending_q;
    if (state_q == S_EXEC) begin
      exec_pending_d = 1'b0;
    end
    if (execute_enable) begin
      exec_pending_d = 1'b1;
    end

    exec_addr_d    = load_exec ? exec_latch_q : exec_addr_q;

    if (go_rise) begin
      byte_count_d = push ? CNT_ONE : '0;
      overflow_d   = drop;
    end else begin
      byte_count_d = byte_count_q;
      if (push && (byte_count_q != '1)) begin
        byte_count_d = byte_count_q + CNT_ONE;
      end
      overflow_d = overflow_q || drop;
    end

    cpu_hold_d = dn_go || !fifo_empty || mem_req || exec_pending_q ||
                 (state_q == S_EXEC);
  end

  // ---------------- control / output registers ----------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      dn_go_q        <= 1'b0;
      exec_pending_q <= 1'b0;
      exec_addr_q    <= '0;
      mem_addr_q     <= '0;
      mem_dout_q     <= '0;
      overflow_q     <= 1'b0;
      byte_count_q   <= '0;
      cpu_hold_q     <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      dn_go_q        <= dn_go;
      exec_pending_q <= exec_pending_d;
      exec_addr_q    <= exec_addr_d;
      mem_addr_q     <= mem_addr_d;
      mem_dout_q     <= mem_dout_d;
      overflow_q     <= overflow_d;
      byte_count_q   <= byte_count_d;
      cpu_hold_q     <= cpu_hold_d;
    end
  end

  // ---------------- storage (no reset needed) ----------------
  // FIFO contents and the latched start address are only ever read after
  // a push / execute_enable has written them.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {dn_addr, dn_data};
    end
    if (execute_enable) begin
      exec_latch_q <= execute_addr;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_dout   = mem_dout_q;
  assign exec_addr  = exec_addr_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;
  assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_dn_sink.sv
module tb_dn_sink;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CAP        = FIFO_DEPTH + 1;  // FIFO plus output register

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              dn_go = 1'b0;
  logic              dn_wr = 1'b0;
  logic [ADDR_W-1:0] dn_addr = '0;
  logic [7:0]        dn_data = '0;
  logic [ADDR_W-1:0] execute_addr = '0;
  logic              execute_enable = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dout;
  logic              mem_ack = 1'b0;
  logic              cpu_hold;
  logic              exec_valid;
  logic [ADDR_W-1:0] exec_addr;
  logic              overflow;
  logic [ADDR_W:0]   byte_count;

  dn_sink #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dn_go(dn_go), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .execute_addr(execute_addr),
    .execute_enable(execute_enable), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .cpu_hold(cpu_hold),
    .exec_valid(exec_valid), .exec_addr(exec_addr), .overflow(overflow),
    .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // memory responder and observers (sampled on the falling edge)
  bit          ack_en = 1'b0;
  int          ack_lat = 1;
  bit          manual_ack = 1'b0;
  int          wait_cnt = 0;
  logic [23:0] obs_q[$];
  int          last_ack_cyc = 0;
  int          exec_cnt = 0;
  int          exec_cyc = 0;
  logic [15:0] exec_seen = '0;
  int          hold_fall_cyc = -1;
  logic        prev_hold = 1'b1;
  int          stab_err = 0;
  int          req_seen = 0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_dout = '0;

  always @(negedge clk_sys) begin : responder
    logic prev_ack;
    prev_ack = mem_ack;
    if (mem_req && prev_req && !prev_ack &&
        (mem_addr !== prev_addr || mem_dout !== prev_dout)) stab_err++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    prev_dout = mem_dout;
    if (mem_req) req_seen++;
    if (exec_valid) begin
      exec_cnt++;
      exec_cyc  = cyc;
      exec_seen = exec_addr;
    end
    if (prev_hold && !cpu_hold) hold_fall_cyc = cyc;
    prev_hold = cpu_hold;
    mem_ack = 1'b0;
    if (!ack_en) begin
      mem_ack  = manual_ack;
      wait_cnt = 0;
    end else if (reset_n && mem_req) begin
      if (prev_ack) wait_cnt = 0;
      if (wait_cnt >= ack_lat) begin
        obs_q.push_back({mem_addr, mem_dout});
        mem_ack      = 1'b1;
        last_ack_cyc = cyc;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic strobe(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk_sys); #1;
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    @(posedge clk_sys); #1;
    dn_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic start_session();
    @(posedge clk_sys); #1; dn_go = 1'b0;
    @(posedge clk_sys); #1; dn_go = 1'b1;
  endtask

  task automatic wait_drain(input int n_exp, input int budget, output bit ok);
    int c;
    c = 0;
    while ((obs_q.size() < n_exp || mem_req) && c < budget) begin
      @(negedge clk_sys);
      c++;
    end
    ok = (c < budget);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    tests_run++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %0h want 0", mem_req); end
    tests_run++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL rst_mem_addr: got %0h want 0", mem_addr); end
    tests_run++; if (mem_dout !== 8'h0) begin fails++; $display("FAIL rst_mem_dout: got %0h want 0", mem_dout); end
    tests_run++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL rst_exec_valid: got %0h want 0", exec_valid); end
    tests_run++; if (exec_addr !== 16'h0) begin fails++; $display("FAIL rst_exec_addr: got %0h want 0", exec_addr); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %0h want 0", overflow); end
    tests_run++; if (byte_count !== 17'h0) begin fails++; $display("FAIL rst_byte_count: got %0h want 0", byte_count); end
    tests_run++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL rst_cpu_hold: got %0h want 1", cpu_hold); end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    idle(2);
    @(negedge clk_sys);
    tests_run++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL rst_release_hold: got %0h want 0", cpu_hold); end
  endtask

  task automatic test_stream();
    logic [23:0] exp[$];
    int ex0, st0;
    bit ok;
    logic [23:0] got;
    ack_en = 1'b1; ack_lat = 1;
    obs_q.delete();
    ex0 = exec_cnt; st0 = stab_err;
    start_session();
    hold_fall_cyc = -1;
    for (int i = 0; i < 10; i++) begin
      exp.push_back({16'(i), 8'(8'hA0 + i)});
      strobe(16'(i), 8'(8'hA0 + i));
    end
    dn_go = 1'b0; execute_enable = 1'b1; execute_addr = 16'h0000;
    @(posedge clk_sys); #1; execute_enable = 1'b0;
    wait_drain(10, 200, ok);
    idle(8);
    tests_run++; if (!ok) begin fails++; $display("FAIL stream_timeout: got %0d writes want 10", obs_q.size()); end
    tests_run++; if (obs_q.size() != 10) begin fails++; $display("FAIL stream_count: got %0d want 10", obs_q.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 24'hxxxxxx;
      tests_run++; if (got !== exp[i]) begin fails++; $display("FAIL stream_write[%0d]: got %06h want %06h", i, got, exp[i]); end
    end
    tests_run++; if (byte_count !== 17'd10) begin fails++; $display("FAIL stream_byte_count: got %0d want 10", byte_count); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL stream_overflow: got %0h want 0", overflow); end
    tests_run++; if (exec_cnt - ex0 != 1) begin fails++; $display("FAIL exec_once: got %0d want 1", exec_cnt - ex0); end
    tests_run++; if (exec_seen !== 16'h0000) begin fails++; $display("FAIL exec_addr: got %0h want 0", exec_seen); end
    tests_run++; if (exec_cyc - last_ack_cyc != 2) begin fails++; $display("FAIL exec_timing: got %0d want 2", exec_cyc - last_ack_cyc); end
    tests_run++; if (hold_fall_cyc - last_ack_cyc != 4) begin fails++; $display("FAIL exec_hold_fall: got %0d want 4", hold_fall_cyc - last_ack_cyc); end
    tests_run++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL exec_hold_low: got %0h want 0", cpu_hold); end
    tests_run++; if (stab_err != st0) begin fails++; $display("FAIL stream_stability: got %0d want %0d", stab_err, st0); end
  endtask

  task automatic test_backpressure();
    logic [23:0] exp[$];
    int st0;
    bit ok;
    logic [23:0] got;
    ack_en = 1'b0; manual_ack = 1'b0;
    obs_q.delete();
    st0 = stab_err;
    start_session();
    for (int i = 0; i < 7; i++) begin
      exp.push_back({16'($urandom), 8'($urandom)});
      strobe(exp[i][23:8], exp[i][7:0]);
    end
    for (int i = 0; i < 8; i++) begin
      dn_addr = 16'($urandom); dn_data = 8'($urandom);
      idle(1);
    end
    @(negedge clk_sys);
    tests_run++; if (byte_count !== 17'(CAP)) begin fails++; $display("FAIL bp_byte_count: got %0d want %0d", byte_count, CAP); end
    tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow: got %0h want 1", overflow); end
    tests_run++; if (mem_req !== 1'b1) begin fails++; $display("FAIL bp_mem_req: got %0h want 1", mem_req); end
    tests_run++; if ({mem_addr, mem_dout} !== exp[0]) begin fails++; $display("FAIL bp_head: got %06h want %06h", {mem_addr, mem_dout}, exp[0]); end
    tests_run++; if (stab_err != st0) begin fails++; $display("FAIL bp_stability: got %0d want %0d", stab_err, st0); end
    ack_en = 1'b1; ack_lat = $urandom_range(0, 2);
    wait_drain(CAP, 200, ok);
    idle(3);
    tests_run++; if (!ok) begin fails++; $display("FAIL bp_timeout: got %0d writes want %0d", obs_q.size(), CAP); end
    tests_run++; if (obs_q.size() != CAP) begin fails++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), CAP); end
    for (int i = 0; i < CAP; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 24'hxxxxxx;
      tests_run++; if (got !== exp[i]) begin fails++; $display("FAIL bp_write[%0d]: got %06h want %06h", i, got, exp[i]); end
    end
    tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_sticky: got %0h want 1", overflow); end
    tests_run++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL bp_hold_session: got %0h want 1", cpu_hold); end
  endtask

  task automatic test_no_execute();
    logic [23:0] exp[$];
    int ex0;
    bit ok;
    logic [23:0] got;
    ack_en = 1'b1; ack_lat = 1;
    obs_q.delete();
    ex0 = exec_cnt;
    start_session();
    hold_fall_cyc = -1;
    idle(1);
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL rise_clears_overflow: got %0h want 0", overflow); end
    for (int i = 0; i < 3; i++) begin
      exp.push_back({16'($urandom), 8'($urandom)});
      strobe(exp[i][23:8], exp[i][7:0]);
    end
    dn_go = 1'b0;
    wait_drain(3, 200, ok);
    idle(6);
    tests_run++; if (!ok) begin fails++; $display("FAIL noexec_timeout: got %0d writes want 3", obs_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 24'hxxxxxx;
      tests_run++; if (got !== exp[i]) begin fails++; $display("FAIL noexec_write[%0d]: got %06h want %06h", i, got, exp[i]); end
    end
    tests_run++; if (byte_count !== 17'd3) begin fails++; $display("FAIL noexec_byte_count: got %0d want 3", byte_count); end
    tests_run++; if (exec_cnt != ex0) begin fails++; $display("FAIL noexec_exec: got %0d pulses want 0", exec_cnt - ex0); end
    tests_run++; if (hold_fall_cyc - last_ack_cyc != 2) begin fails++; $display("FAIL noexec_hold_fall: got %0d want 2", hold_fall_cyc - last_ack_cyc); end
    tests_run++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL noexec_hold_low: got %0h want 0", cpu_hold); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      logic [23:0] exp[$];
      logic [15:0] a1, a2;
      int n, ex0;
      bit ok;
      logic [23:0] got;
      ack_en = 1'b1; ack_lat = $urandom_range(0, 3);
      n = $urandom_range(3, 8);
      a2 = 16'($urandom); a1 = ~a2;
      obs_q.delete();
      ex0 = exec_cnt;
      start_session();
      hold_fall_cyc = -1;
      for (int i = 0; i < n; i++) begin
        exp.push_back({16'($urandom), 8'($urandom)});
        strobe(exp[i][23:8], exp[i][7:0]);
        if (i == 1) begin
          execute_enable = 1'b1; execute_addr = a1;
          @(posedge clk_sys); #1; execute_enable = 1'b0;
        end
        if (i != n - 1) idle($urandom_range(3, 6));
      end
      dn_go = 1'b0; execute_enable = 1'b1; execute_addr = a2;
      @(posedge clk_sys); #1; execute_enable = 1'b0;
      wait_drain(n, 300, ok);
      idle(8);
      tests_run++; if (!ok || obs_q.size() != n) begin fails++; $display("FAIL rnd%0d_count: got %0d want %0d", r, obs_q.size(), n); end
      for (int i = 0; i < n; i++) begin
        got = (i < obs_q.size()) ? obs_q[i] : 24'hxxxxxx;
        tests_run++; if (got !== exp[i]) begin fails++; $display("FAIL rnd%0d_write[%0d]: got %06h want %06h", r, i, got, exp[i]); end
      end
      tests_run++; if (byte_count !== 17'(n)) begin fails++; $display("FAIL rnd%0d_byte_count: got %0d want %0d", r, byte_count, n); end
      tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL rnd%0d_overflow: got %0h want 0", r, overflow); end
      tests_run++; if (exec_cnt - ex0 != 1) begin fails++; $display("FAIL rnd%0d_exec_once: got %0d want 1", r, exec_cnt - ex0); end
      tests_run++; if (exec_seen !== a2) begin fails++; $display("FAIL rnd%0d_exec_addr: got %0h want %0h", r, exec_seen, a2); end
      tests_run++; if (exec_addr !== a2) begin fails++; $display("FAIL rnd%0d_exec_addr_held: got %0h want %0h", r, exec_addr, a2); end
      tests_run++; if (exec_cyc - last_ack_cyc != 2) begin fails++; $display("FAIL rnd%0d_exec_timing: got %0d want 2", r, exec_cyc - last_ack_cyc); end
      tests_run++; if (hold_fall_cyc - last_ack_cyc != 4) begin fails++; $display("FAIL rnd%0d_hold_fall: got %0d want 4", r, hold_fall_cyc - last_ack_cyc); end
    end
  endtask

  task automatic test_reset_mid_write();
    int rq0, ex0;
    ack_en = 1'b0; manual_ack = 1'b0;
    start_session();
    for (int i = 0; i < 4; i++) strobe(16'($urandom), 8'($urandom));
    execute_enable = 1'b1; execute_addr = 16'h1234;
    @(posedge clk_sys); #1; execute_enable = 1'b0;
    @(negedge clk_sys);
    tests_run++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rmw_pre_req: got %0h want 1", mem_req); end
    @(posedge clk_sys); #3;
    reset_n = 1'b0; dn_go = 1'b0;
    #1;
    tests_run++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rmw_async_req: got %0h want 0", mem_req); end
    tests_run++; if ({mem_addr, mem_dout} !== 24'h0) begin fails++; $display("FAIL rmw_async_data: got %06h want 0", {mem_addr, mem_dout}); end
    tests_run++; if (byte_count !== 17'h0) begin fails++; $display("FAIL rmw_async_count: got %0d want 0", byte_count); end
    tests_run++; if (exec_addr !== 16'h0) begin fails++; $display("FAIL rmw_async_exec_addr: got %0h want 0", exec_addr); end
    tests_run++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL rmw_async_hold: got %0h want 1", cpu_hold); end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    rq0 = req_seen; ex0 = exec_cnt;
    manual_ack = 1'b1;
    @(posedge clk_sys); #1; manual_ack = 1'b0;
    idle(10);
    @(negedge clk_sys);
    tests_run++; if (req_seen != rq0) begin fails++; $display("FAIL rmw_no_write: got %0d req cycles want 0", req_seen - rq0); end
    tests_run++; if (exec_cnt != ex0) begin fails++; $display("FAIL rmw_no_exec: got %0d want 0", exec_cnt - ex0); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL rmw_overflow: got %0h want 0", overflow); end
    tests_run++; if (byte_count !== 17'h0) begin fails++; $display("FAIL rmw_byte_count: got %0d want 0", byte_count); end
    tests_run++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL rmw_hold: got %0h want 0", cpu_hold); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_no_execute();
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
